// File: rtl/amplitude_request_arbiter.sv
// Round-robin arbiter sharing one amplitude cofactor unit among alpha, beta, stabilizer and amp2.
// Optional watchdog abort is enabled by defining AMP_ARB_WATCHDOG_EN.
module amplitude_request_arbiter #(
  parameter int num_qubit      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_new,
  input  logic [3:0]  req,
  input  logic [31:0] counter_valid_in,
  input  logic        ready_cofactor,
  input  logic        done_amplitude,
  input  logic        fsm_amplitude_busy,
  input  logic        done_alpha,
  input  logic        valid_out,
  output logic [3:0]  grant,
  output logic        det_alpha,
  output logic        det_beta,
  output logic        det_stab,
  output logic        det_amp2,
  output logic [31:0] counter_valid_vector,
  output logic [3:0]  done_req,
  output logic        skip,
  output logic        busy,
  output logic        timeout_err
);

  if (num_qubit < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("amplitude_request_arbiter: num_qubit and TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ROTATE,
    S_DRAIN,
    S_HOLD_A,
    S_RELEASE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_rr_ptr;
  logic [3:0]  r_det;
  logic        r_vo_seen;
  logic        r_skip_pend;

  logic        w_found;
  logic [1:0]  w_winner;
  logic [1:0]  w_cand;
  logic [3:0]  w_onehot;

  // Scan from the farthest candidate to the nearest so the first set bit at/after rr_ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_cand   = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_rr_ptr + 2'(k);
      if (req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
    w_onehot = 4'b0001 << w_winner;
  end

  assign det_alpha = r_det[0];
  assign det_beta  = r_det[1];
  assign det_stab  = r_det[2];
  assign det_amp2  = r_det[3];
  assign busy      = (r_state != S_IDLE);

`ifdef AMP_ARB_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      r_state              <= S_IDLE;
      r_rr_ptr             <= 2'd0;
      r_det                <= 4'd0;
      r_vo_seen            <= 1'b0;
      r_skip_pend          <= 1'b0;
      grant                <= 4'd0;
      done_req             <= 4'd0;
      skip                 <= 1'b0;
      counter_valid_vector <= 32'd0;
`ifdef AMP_ARB_WATCHDOG_EN
      timeout_err          <= 1'b0;
      r_wd_cnt             <= 32'd0;
`endif
    end else begin
      r_det    <= 4'd0;
      done_req <= 4'd0;
      skip     <= 1'b0;

      // A consumer pulse seen early is remembered until the grant is released.
      if (valid_out && (r_state == S_ROTATE || r_state == S_DRAIN || r_state == S_HOLD_A))
        r_vo_seen <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_found && ready_cofactor) begin
            grant                <= w_onehot;
            counter_valid_vector <= counter_valid_in;
            r_rr_ptr             <= w_winner + 2'd1;
            if (counter_valid_in == 32'd0) begin
              r_skip_pend <= 1'b1;
              r_state     <= S_RELEASE;
            end else begin
              r_skip_pend <= 1'b0;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_det   <= grant;
          r_state <= S_ROTATE;
        end
        S_ROTATE: begin
          if (done_amplitude)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!fsm_amplitude_busy) begin
            if (grant[0]) begin
              if (done_alpha)
                r_state <= S_HOLD_A;
            end else begin
              r_state <= S_RELEASE;
            end
          end
        end
        S_HOLD_A: begin
          if (valid_out || r_vo_seen)
            r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          done_req    <= grant;
          skip        <= r_skip_pend;
          grant       <= 4'd0;
          r_skip_pend <= 1'b0;
          r_vo_seen   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef AMP_ARB_WATCHDOG_EN
      timeout_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_wd_cnt <= 32'd0;
      end else if (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        // Abort the stuck transaction: report it to the owner without the skip flag.
        timeout_err <= 1'b1;
        done_req    <= grant;
        skip        <= 1'b0;
        grant       <= 4'd0;
        r_det       <= 4'd0;
        r_skip_pend <= 1'b0;
        r_vo_seen   <= 1'b0;
        r_wd_cnt    <= 32'd0;
        r_state     <= S_IDLE;
      end else begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_amplitude_request_arbiter.sv
// Directed bench for amplitude_request_arbiter: reset, round-robin, drain/hold paths, skip, ready gating, abort.
module tb_amplitude_request_arbiter;

  logic        clk;
  logic        rst_new;
  logic [3:0]  req;
  logic [31:0] counter_valid_in;
  logic        ready_cofactor;
  logic        done_amplitude;
  logic        fsm_amplitude_busy;
  logic        done_alpha;
  logic        valid_out;
  logic [3:0]  grant;
  logic        det_alpha, det_beta, det_stab, det_amp2;
  logic [31:0] counter_valid_vector;
  logic [3:0]  done_req;
  logic        skip;
  logic        busy;
  logic        timeout_err;

  int total;
  int bad;

  amplitude_request_arbiter #(
    .num_qubit(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_new(rst_new),
    .req(req),
    .counter_valid_in(counter_valid_in),
    .ready_cofactor(ready_cofactor),
    .done_amplitude(done_amplitude),
    .fsm_amplitude_busy(fsm_amplitude_busy),
    .done_alpha(done_alpha),
    .valid_out(valid_out),
    .grant(grant),
    .det_alpha(det_alpha),
    .det_beta(det_beta),
    .det_stab(det_stab),
    .det_amp2(det_amp2),
    .counter_valid_vector(counter_valid_vector),
    .done_req(done_req),
    .skip(skip),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (grant !== 4'd0) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL rst_done got=%b want=0000", done_req); end
    total++; if ({det_alpha, det_beta, det_stab, det_amp2} !== 4'd0) begin bad++; $display("FAIL rst_det got=%b want=0000", {det_alpha, det_beta, det_stab, det_amp2}); end
    total++; if ({skip, busy, timeout_err} !== 3'd0) begin bad++; $display("FAIL rst_flags got=%b want=000", {skip, busy, timeout_err}); end
    total++; if (counter_valid_vector !== 32'd0) begin bad++; $display("FAIL rst_cvv got=%0d want=0", counter_valid_vector); end
    rst_new = 1'b0;
    step();
  endtask

  // Cofactor stand-in: rotate completes with an early valid_out, write-out is instantaneous.
  task automatic serve(output logic [3:0] g, output logic [3:0] dr, output logic ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (grant == 4'd0 && n < 20) begin step(); n++; end
    g = grant;
    if (g == 4'd0) ok = 1'b0;
    n = 0;
    while ({det_alpha, det_beta, det_stab, det_amp2} == 4'd0 && n < 20) begin step(); n++; end
    if ({det_amp2, det_stab, det_beta, det_alpha} != g) ok = 1'b0;
    done_amplitude = 1'b1;
    valid_out      = 1'b1;
    step();
    done_amplitude = 1'b0;
    valid_out      = 1'b0;
    n = 0;
    while (done_req == 4'd0 && n < 20) begin step(); n++; end
    dr = done_req;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [3:0] g, dr;
    logic ok;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111; counter_valid_in = 32'd6; done_alpha = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve(g, dr, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_handshake%0d got=%b want=1", i, ok); end
      total++; if (g !== exp_g[i]) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", i, g, exp_g[i]); end
      total++; if (dr !== exp_g[i]) begin bad++; $display("FAIL rr_done%0d got=%b want=%b", i, dr, exp_g[i]); end
    end
    req = 4'd0; done_alpha = 1'b0;
    step();
  endtask

  task automatic test_beta();
    req = 4'b0010; counter_valid_in = 32'd8; ready_cofactor = 1'b1;
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL beta_grant got=%b want=0010", grant); end
    total++; if (det_beta !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL beta_early got det=%b busy=%b want det=0 busy=1", det_beta, busy); end
    step();
    total++; if ({det_amp2, det_stab, det_beta, det_alpha} !== 4'b0010) begin bad++; $display("FAIL beta_det got=%b want=0010", {det_amp2, det_stab, det_beta, det_alpha}); end
    total++; if (counter_valid_vector !== 32'd8) begin bad++; $display("FAIL beta_cvv got=%0d want=8", counter_valid_vector); end
    step();
    total++; if (det_beta !== 1'b0) begin bad++; $display("FAIL beta_det_pulse got=%b want=0", det_beta); end
    step();
    step();
    done_amplitude = 1'b1; fsm_amplitude_busy = 1'b1;
    step();
    done_amplitude = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      total++; if (done_req !== 4'd0) begin bad++; $display("FAIL beta_drain%0d got=%b want=0000", i, done_req); end
    end
    fsm_amplitude_busy = 1'b0;
    step();
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL beta_release_early got=%b want=0000", done_req); end
    step();
    total++; if (done_req !== 4'b0010 || skip !== 1'b0) begin bad++; $display("FAIL beta_done got=%b skip=%b want=0010 skip=0", done_req, skip); end
    total++; if (grant !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL beta_idle got grant=%b busy=%b want 0000/0", grant, busy); end
    req = 4'd0;
    step();
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL beta_done_pulse got=%b want=0000", done_req); end
  endtask

  task automatic test_alpha_early_vo();
    req = 4'b0001; counter_valid_in = 32'd4;
    step();
    step();
    total++; if (det_alpha !== 1'b1) begin bad++; $display("FAIL alpha_det got=%b want=1", det_alpha); end
    done_amplitude = 1'b1; fsm_amplitude_busy = 1'b1;
    step();
    done_amplitude = 1'b0;
    step();
    valid_out = 1'b1;
    step();
    valid_out = 1'b0; fsm_amplitude_busy = 1'b0;
    step();
    step();
    total++; if (done_req !== 4'd0 || busy !== 1'b1) begin bad++; $display("FAIL alpha_wait got done=%b busy=%b want 0000/1", done_req, busy); end
    done_alpha = 1'b1;
    step();
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL alpha_hold got=%b want=0000", done_req); end
    step();
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL alpha_release got=%b want=0000", done_req); end
    step();
    total++; if (done_req !== 4'b0001 || skip !== 1'b0) begin bad++; $display("FAIL alpha_done got=%b skip=%b want=0001 skip=0", done_req, skip); end
    req = 4'd0; done_alpha = 1'b0;
    step();
  endtask

  task automatic test_skip();
    req = 4'b0100; counter_valid_in = 32'd0;
    step();
    total++; if (grant !== 4'b0100 || det_stab !== 1'b0) begin bad++; $display("FAIL skip_grant got=%b det=%b want=0100 det=0", grant, det_stab); end
    step();
    total++; if (done_req !== 4'b0100 || skip !== 1'b1) begin bad++; $display("FAIL skip_done got=%b skip=%b want=0100 skip=1", done_req, skip); end
    total++; if (det_stab !== 1'b0) begin bad++; $display("FAIL skip_nodet got=%b want=0", det_stab); end
    req = 4'd0;
    step();
    total++; if (skip !== 1'b0 || done_req !== 4'd0) begin bad++; $display("FAIL skip_pulse got skip=%b done=%b want 0/0000", skip, done_req); end
  endtask

  task automatic test_ready_wait();
    ready_cofactor = 1'b0; req = 4'b1000; counter_valid_in = 32'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (grant !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL rdy_hold%0d got grant=%b busy=%b want 0000/0", i, grant, busy); end
    end
    ready_cofactor = 1'b1;
    step();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL rdy_grant got=%b want=1000", grant); end
    step();
    total++; if ({det_amp2, det_stab, det_beta, det_alpha} !== 4'b1000) begin bad++; $display("FAIL rdy_det got=%b want=1000", {det_amp2, det_stab, det_beta, det_alpha}); end
    total++; if (counter_valid_vector !== 32'd3) begin bad++; $display("FAIL rdy_cvv got=%0d want=3", counter_valid_vector); end
    done_amplitude = 1'b1;
    step();
    done_amplitude = 1'b0;
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL nosk_drain got=%b want=0000", done_req); end
    step();
    total++; if (done_req !== 4'd0) begin bad++; $display("FAIL nosk_release got=%b want=0000", done_req); end
    step();
    total++; if (done_req !== 4'b1000) begin bad++; $display("FAIL nosk_done got=%b want=1000", done_req); end
    req = 4'd0;
    step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010; counter_valid_in = 32'd5;
    step();
    step();
    step();
`ifndef AMP_ARB_WATCHDOG_EN
    for (int i = 0; i < 20; i++) step();
    total++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL stall_nowd got busy=%b to=%b want 1/0", busy, timeout_err); end
`endif
    rst_new = 1'b1;
    #1;
    total++; if (grant !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst got grant=%b busy=%b want 0000/0", grant, busy); end
    total++; if (counter_valid_vector !== 32'd0 || done_req !== 4'd0) begin bad++; $display("FAIL mid_rst_out got cvv=%0d done=%b want 0/0000", counter_valid_vector, done_req); end
    req = 4'd0;
    step();
    rst_new = 1'b0;
    step();
    total++; if (done_req !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_after got done=%b busy=%b want 0000/0", done_req, busy); end
  endtask

`ifdef AMP_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    req = 4'b0001; counter_valid_in = 32'd2;
    step();
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL wd_cycle got=%0d want=16", n); end
    total++; if (done_req !== 4'b0001 || skip !== 1'b0) begin bad++; $display("FAIL wd_done got=%b skip=%b want=0001 skip=0", done_req, skip); end
    req = 4'd0;
    step();
    total++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL wd_idle got busy=%b to=%b want 0/0", busy, timeout_err); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst_new = 1'b1;
    req = 4'd0;
    counter_valid_in = 32'd0;
    ready_cofactor = 1'b1;
    done_amplitude = 1'b0;
    fsm_amplitude_busy = 1'b0;
    done_alpha = 1'b0;
    valid_out = 1'b0;
    test_reset();
    test_round_robin();
    test_beta();
    test_alpha_early_vo();
    test_skip();
    test_ready_wait();
    test_reset_mid();
`ifdef AMP_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
